alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 115 +++++++++++
 tb/tb_alu_share_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU among N_REQ requesters. Each operation takes three cycles: IDLE, then EXEC, then RESP.
// Define ALU_SHARE_ARB_RR_EN to get round-robin arbitration. Without it, index 0 always has the highest priority.
package alu_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef struct packed {
        alu_op_e            code;
        logic signed [31:0] a;
        logic signed [31:0] b;
    } alu_data_t;
endpackage

module alu_share_arb
    import alu_types_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  alu_data_t [N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic signed [31:0]       rsp_data,
    output alu_data_t                alu_data,
    input  logic signed [31:0]       alu_result,
    output logic                     busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e             state;
    logic [PW-1:0]      grant;
    logic [PW-1:0]      p;
    logic [PW-1:0]      sel;
    logic [PW-1:0]      cand;
    logic               sel_found;
    logic signed [31:0] result_q;

`ifndef ALU_SHARE_ARB_RR_EN
    assign p = '0;
`endif

    assign rsp_data = result_q;

    // Search the requesters starting at the priority pointer and pick the first one that is valid.
    always_comb begin
        sel       = '0;
        cand      = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PW'((int'(p) + i) % N_REQ);
            if (!sel_found && req_valid[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    // The grant is combinational so the accept lands in the request cycle; it is masked while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && sel_found) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            rsp_valid <= '0;
            alu_data  <= '0;
            result_q  <= '0;
`ifdef ALU_SHARE_ARB_RR_EN
            p         <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant    <= sel;
                        alu_data <= req_data[sel];
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q  <= alu_result;
                    alu_data  <= '0;
                    rsp_valid <= N_REQ'(1) << grant;
                    state     <= RESP;
                end
                RESP: begin
                    // Only the granted requester's rsp_ready can finish the transaction.
                    if (rsp_ready[grant]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef ALU_SHARE_ARB_RR_EN
                        p <= (grant == PW'(N_REQ - 1)) ? '0 : grant + PW'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb. It covers a two-requester instance and a four-requester instance for the wrap check.
// Expected values depend on whether ALU_SHARE_ARB_RR_EN is defined.
module tb_alu_share_arb;
    import alu_types_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rv2 = '0, rr2, sv2, sr2 = '0;
    alu_data_t [1:0]    rd2 = '0;
    alu_data_t          ad2;
    logic signed [31:0] sd2, ar2;
    logic               b2;

    logic [3:0]         rv4 = '0, rr4, sv4, sr4 = '0;
    alu_data_t [3:0]    rd4 = '0;
    alu_data_t          ad4;
    logic signed [31:0] sd4, ar4;
    logic               b4;

    int tests = 0;
    int failures = 0;

`ifdef ALU_SHARE_ARB_RR_EN
    localparam logic [1:0] CONT_G [3] = '{2'b10, 2'b01, 2'b10};
    localparam logic [3:0] WRAP_G [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam int         WRAP_D [5] = '{100, 101, 102, 103, 100};
`else
    localparam logic [1:0] CONT_G [3] = '{2'b01, 2'b01, 2'b01};
    localparam logic [3:0] WRAP_G [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    localparam int         WRAP_D [5] = '{100, 100, 100, 100, 100};
`endif

    alu_share_arb #(.N_REQ(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(rr2), .req_data(rd2),
        .rsp_valid(sv2), .rsp_ready(sr2), .rsp_data(sd2), .alu_data(ad2),
        .alu_result(ar2), .busy(b2)
    );

    alu_share_arb #(.N_REQ(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rr4), .req_data(rd4),
        .rsp_valid(sv4), .rsp_ready(sr4), .rsp_data(sd4), .alu_data(ad4),
        .alu_result(ar4), .busy(b4)
    );

    function automatic alu_data_t mkOp(input alu_op_e c, input int a, input int b);
        alu_data_t d;
        d.code = c;
        d.a    = a;
        d.b    = b;
        return d;
    endfunction

    // Reference model of the external ALU.
    function automatic logic signed [31:0] aluModel(input alu_data_t d);
        case (d.code)
            ALU_ADD:  return d.a + d.b;
            ALU_SUB:  return d.a - d.b;
            ALU_AND:  return d.a & d.b;
            ALU_OR:   return d.a | d.b;
            ALU_XOR:  return d.a ^ d.b;
            ALU_SLL:  return d.a << d.b[4:0];
            ALU_SRL:  return d.a >> d.b[4:0];
            ALU_SRA:  return d.a >>> d.b[4:0];
            ALU_SLT:  return {31'b0, d.a < d.b};
            ALU_SLTU: return {31'b0, $unsigned(d.a) < $unsigned(d.b)};
            default:  return '0;
        endcase
    endfunction

    always_comb ar2 = aluModel(ad2);
    always_comb ar4 = aluModel(ad4);

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rdy);
        rv2 = v;
        sr2 = rdy;
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one full transaction on the two-requester instance with rsp_ready held high.
    task automatic serve(input string tag, input logic [1:0] vAcc, input logic [1:0] vAfter,
                         input logic [1:0] expG, input logic signed [31:0] expD);
        alu_data_t expOp;
        expOp = expG[0] ? rd2[0] : rd2[1];
        applyStimulus(vAcc, 2'b11);
        checkOutput({tag, "_grant"}, rr2, expG);
        checkOutput({tag, "_idle_busy"}, b2, 1'b0);
        checkOutput({tag, "_idle_alu"}, ad2, '0);
        tick();
        applyStimulus(vAfter, 2'b11);
        checkOutput({tag, "_exec_busy"}, b2, 1'b1);
        checkOutput({tag, "_exec_ready"}, rr2, 2'b00);
        checkOutput({tag, "_exec_alu"}, ad2, expOp);
        checkOutput({tag, "_exec_rspv"}, sv2, 2'b00);
        tick();
        checkOutput({tag, "_resp_valid"}, sv2, expG);
        checkOutput({tag, "_resp_data"}, sd2, expD);
        checkOutput({tag, "_resp_alu"}, ad2, '0);
        checkOutput({tag, "_resp_busy"}, b2, 1'b1);
        tick();
        checkOutput({tag, "_done_busy"}, b2, 1'b0);
        checkOutput({tag, "_done_rspv"}, sv2, 2'b00);
        checkOutput({tag, "_done_hold"}, sd2, expD);
    endtask

    initial begin
        // While reset is held, every output must be zero even if requests are pending.
        rv2 = 2'b11;
        rv4 = 4'b1111;
        #1;
        checkOutput("rst_ready2", rr2, 2'b00);
        checkOutput("rst_ready4", rr4, 4'b0000);
        checkOutput("rst_rspv", sv2, 2'b00);
        checkOutput("rst_data", sd2, 32'sd0);
        checkOutput("rst_alu", ad2, '0);
        checkOutput("rst_busy", b2, 1'b0);
        rv2 = 2'b00;
        rv4 = 4'b0000;
        resetDut();

        // A single ADD request.
        rd2[0] = mkOp(ALU_ADD, 5, 7);
        serve("add", 2'b01, 2'b00, 2'b01, 32'sd12);

        // Contention starting with the priority pointer freshly reset.
        resetDut();
        rd2[0] = mkOp(ALU_SUB, 10, 3);
        rd2[1] = mkOp(ALU_SRA, -16, 2);
        serve("pair0", 2'b11, 2'b10, 2'b01, 32'sd7);
        serve("pair1", 2'b10, 2'b00, 2'b10, -32'sd4);
        serve("solo0", 2'b01, 2'b00, 2'b01, 32'sd7);
        for (int k = 0; k < 3; k++) begin
            serve("cont", 2'b11, 2'b11, CONT_G[k], CONT_G[k][0] ? 32'sd7 : -32'sd4);
        end

        // Backpressure: the result stays stable, and rsp_ready on the other index has no effect.
        rd2[0] = mkOp(ALU_SLTU, 1, -1);
        applyStimulus(2'b01, 2'b00);
        checkOutput("bp_grant", rr2, 2'b01);
        tick();
        applyStimulus(2'b00, 2'b00);
        tick();
        applyStimulus(2'b10, 2'b10);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_rspv", sv2, 2'b01);
            checkOutput("bp_data", sd2, 32'sd1);
            checkOutput("bp_ready", rr2, 2'b00);
            checkOutput("bp_busy", b2, 1'b1);
            tick();
        end
        applyStimulus(2'b00, 2'b01);
        tick();
        checkOutput("bp_release_rspv", sv2, 2'b00);
        checkOutput("bp_release_busy", b2, 1'b0);

        // Reset during EXEC drops the operation.
        rd2[0] = mkOp(ALU_ADD, 1, 1);
        applyStimulus(2'b01, 2'b01);
        checkOutput("rx_grant", rr2, 2'b01);
        tick();
        applyStimulus(2'b00, 2'b01);
        checkOutput("rx_exec_busy", b2, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rx_busy", b2, 1'b0);
        checkOutput("rx_alu", ad2, '0);
        checkOutput("rx_data", sd2, 32'sd0);
        checkOutput("rx_rspv", sv2, 2'b00);
        checkOutput("rx_ready", rr2, 2'b00);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("rx_post_rspv", sv2, 2'b00);
            checkOutput("rx_post_busy", b2, 1'b0);
        end
        applyStimulus(2'b11, 2'b00);
        checkOutput("rx_ptr_zero", rr2, 2'b01);
        applyStimulus(2'b00, 2'b00);

        // Pointer wrap on the four-requester instance.
        for (int i = 0; i < 4; i++) rd4[i] = mkOp(ALU_ADD, 100, i);
        rv4 = 4'b1111;
        sr4 = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("wrap_grant", rr4, WRAP_G[k]);
            tick();
            tick();
            checkOutput("wrap_rspv", sv4, WRAP_G[k]);
            checkOutput("wrap_data", sd4, WRAP_D[k]);
            tick();
        end
        rv4 = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
